// File: rtl/buzz_arbiter.sv
// Buzzer ownership arbiter: alarm > timer > click, on-times counted in ticks of TICK_DIV clocks.
// Outputs are registered from the next state, so a grant is visible the cycle after its request.
module buzz_arbiter #(
  parameter int TICK_DIV      = 500000,
  parameter int CLICK_TICKS   = 5,
  parameter int TIMER_TICKS   = 300,
  parameter int ALARM_TIMEOUT = 6000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_alarm_req,
  input  logic       i_timer_req,
  input  logic       i_click_req,
  input  logic       i_ack,
  output logic       o_buzz_en,
  output logic [1:0] o_tone_sel,
  output logic [2:0] o_grant,
  output logic       o_busy
);

  // state    | meaning
  // ST_IDLE  | silent, arbitrating pending/new requests
  // ST_CLICK | key-click tone, preemptible by alarm or timer
  // ST_TIMER | timer-expiry tone, silenced by ack
  // ST_ALARM | alarm tone until ack or timeout
  // ST_HOLD  | silent, waiting for the alarm match to drop
  typedef enum logic [2:0] {ST_IDLE, ST_CLICK, ST_TIMER, ST_ALARM, ST_HOLD} state_e;

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [TW-1:0] tick_cnt_q;
  logic          tick;
  state_e        state_q, state_d;
  logic [15:0]   dur_q, dur_d, dur_dec;
  logic          timer_pend_q, timer_pend_d;
  logic          click_pend_q, click_pend_d;
  logic          timer_req, click_req, dur_last;

  assign tick      = (tick_cnt_q == TW'(TICK_DIV - 1));
  assign timer_req = i_timer_req | timer_pend_q;
  assign click_req = i_click_req | click_pend_q;
  assign dur_last  = tick && (dur_q <= 16'd1);
  assign dur_dec   = tick ? (dur_q - 16'd1) : dur_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_cnt_q <= '0;
    end else if (tick) begin
      tick_cnt_q <= '0;
    end else begin
      tick_cnt_q <= tick_cnt_q + TW'(1);
    end
  end

  always_comb begin
    state_d      = state_q;
    dur_d        = dur_q;
    timer_pend_d = timer_pend_q | i_timer_req;
    click_pend_d = click_pend_q | i_click_req;
    unique case (state_q)
      ST_IDLE: begin
        if (i_alarm_req) begin
          state_d      = ST_ALARM;
          dur_d        = 16'(ALARM_TIMEOUT);
          click_pend_d = 1'b0;
        end else if (timer_req) begin
          state_d      = ST_TIMER;
          dur_d        = 16'(TIMER_TICKS);
          timer_pend_d = 1'b0;
          click_pend_d = 1'b0;
        end else if (click_req) begin
          state_d      = ST_CLICK;
          dur_d        = 16'(CLICK_TICKS);
          click_pend_d = 1'b0;
        end
      end
      ST_CLICK: begin
        if (i_alarm_req) begin
          state_d      = ST_ALARM;
          dur_d        = 16'(ALARM_TIMEOUT);
          click_pend_d = 1'b0;
        end else if (timer_req) begin
          state_d      = ST_TIMER;
          dur_d        = 16'(TIMER_TICKS);
          timer_pend_d = 1'b0;
          click_pend_d = 1'b0;
        end else if (dur_last) begin
          state_d = ST_IDLE;
          dur_d   = '0;
        end else begin
          dur_d = dur_dec;
        end
      end
      ST_TIMER: begin
        click_pend_d = 1'b0;
        // Ack also swallows a retrigger arriving in the same cycle.
        if (i_ack) begin
          state_d      = ST_IDLE;
          dur_d        = '0;
          timer_pend_d = 1'b0;
        end else if (i_alarm_req) begin
          state_d      = ST_ALARM;
          dur_d        = 16'(ALARM_TIMEOUT);
          timer_pend_d = 1'b1;
        end else if (i_timer_req) begin
          dur_d        = 16'(TIMER_TICKS);
          timer_pend_d = 1'b0;
        end else begin
          timer_pend_d = 1'b0;
          if (dur_last) begin
            state_d = ST_IDLE;
            dur_d   = '0;
          end else begin
            dur_d = dur_dec;
          end
        end
      end
      ST_ALARM: begin
        click_pend_d = 1'b0;
        if (i_ack || dur_last) begin
          state_d = ST_HOLD;
          dur_d   = '0;
        end else begin
          dur_d = dur_dec;
        end
      end
      ST_HOLD: begin
        click_pend_d = 1'b0;
        if (!i_alarm_req) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        dur_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      dur_q        <= '0;
      timer_pend_q <= 1'b0;
      click_pend_q <= 1'b0;
      o_buzz_en    <= 1'b0;
      o_tone_sel   <= 2'b00;
      o_grant      <= 3'b000;
      o_busy       <= 1'b0;
    end else begin
      state_q      <= state_d;
      dur_q        <= dur_d;
      timer_pend_q <= timer_pend_d;
      click_pend_q <= click_pend_d;
      o_buzz_en    <= (state_d == ST_CLICK) || (state_d == ST_TIMER) || (state_d == ST_ALARM);
      o_busy       <= (state_d != ST_IDLE);
      case (state_d)
        ST_CLICK: begin
          o_tone_sel <= 2'b01;
          o_grant    <= 3'b001;
        end
        ST_TIMER: begin
          o_tone_sel <= 2'b10;
          o_grant    <= 3'b010;
        end
        ST_ALARM: begin
          o_tone_sel <= 2'b11;
          o_grant    <= 3'b100;
        end
        default: begin
          o_tone_sel <= 2'b00;
          o_grant    <= 3'b000;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_buzz_arbiter.sv
// Scoreboard bench for buzz_arbiter: each output change is matched against a queued
// expected value and the allowed number of cycles the previous output value lasted.
`timescale 1ns/1ps
module tb_buzz_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       alarm = 1'b0, timer = 1'b0, click = 1'b0, ack = 1'b0;
  logic       buzz, busy;
  logic [1:0] tone;
  logic [2:0] grant;
  logic [6:0] outv;

  int checks = 0;
  int failures = 0;
  int scn = 0;

  // {buzz, tone_sel, grant, busy}
  localparam logic [6:0] V_IDLE  = 7'b0_00_000_0;
  localparam logic [6:0] V_CLICK = 7'b1_01_001_1;
  localparam logic [6:0] V_TIMER = 7'b1_10_010_1;
  localparam logic [6:0] V_ALARM = 7'b1_11_100_1;
  localparam logic [6:0] V_HOLD  = 7'b0_00_000_1;
  localparam int ANY = 100000;

  typedef struct {
    logic [6:0] val;
    int         gmin;
    int         gmax;
    int         tag;
  } exp_t;

  exp_t exp_q[$];

  buzz_arbiter #(
    .TICK_DIV(4), .CLICK_TICKS(2), .TIMER_TICKS(5), .ALARM_TIMEOUT(8)
  ) dut (
    .clk(clk), .rst(rst),
    .i_alarm_req(alarm), .i_timer_req(timer), .i_click_req(click), .i_ack(ack),
    .o_buzz_en(buzz), .o_tone_sel(tone), .o_grant(grant), .o_busy(busy)
  );

  assign outv = {buzz, tone, grant, busy};

  always #5 clk = ~clk;

  logic [6:0] prev_v = 7'b0;
  int         cyc = 0;
  int         last_cyc = 0;
  int         mon_gap;
  exp_t       mon_e;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (outv !== prev_v) begin
      mon_gap  = cyc - last_cyc;
      last_cyc = cyc;
      prev_v   = outv;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL scn%0d_unexpected_change got=%b want=no change", scn, outv);
      end else begin
        mon_e = exp_q.pop_front();
        checks++;
        if (outv !== mon_e.val) begin
          failures++;
          $display("FAIL scn%0d_value got=%b want=%b", mon_e.tag, outv, mon_e.val);
        end
        checks++;
        if (mon_gap < mon_e.gmin || mon_gap > mon_e.gmax) begin
          failures++;
          $display("FAIL scn%0d_duration got=%0d want=%0d..%0d", mon_e.tag, mon_gap,
                   mon_e.gmin, mon_e.gmax);
        end
      end
    end
  end

  function automatic void push(input logic [6:0] v, input int lo, input int hi);
    exp_t e;
    e.val  = v;
    e.gmin = lo;
    e.gmax = hi;
    e.tag  = scn;
    exp_q.push_back(e);
  endfunction

  task automatic check(input string name, input logic [6:0] got, input logic [6:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%b want=%b", name, got, want);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    repeat (25) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scn%0d_drain got=%0d outstanding want=0", scn, exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    wait_cyc(3);
    check("reset_state", outv, V_IDLE);
    rst = 1'b0;
    wait_cyc(2);

    // single click
    scn = 1;
    push(V_CLICK, 0, ANY);
    push(V_IDLE, 5, 8);
    click = 1'b1;
    wait_cyc(1);
    click = 1'b0;
    check("click_latency", outv, V_CLICK);
    drain();

    // timer preempts click two cycles in; click not replayed
    scn = 2;
    push(V_CLICK, 0, ANY);
    push(V_TIMER, 2, 2);
    push(V_IDLE, 17, 20);
    click = 1'b1;
    wait_cyc(1);
    click = 1'b0;
    wait_cyc(1);
    timer = 1'b1;
    wait_cyc(1);
    timer = 1'b0;
    check("timer_preempt", outv, V_TIMER);
    drain();

    // alarm preempts timer, ack to hold, release, timer replays in full
    scn = 3;
    push(V_TIMER, 0, ANY);
    push(V_ALARM, 3, 3);
    push(V_HOLD, 4, 4);
    push(V_IDLE, 3, 3);
    push(V_TIMER, 1, 1);
    push(V_IDLE, 17, 20);
    timer = 1'b1;
    wait_cyc(1);
    timer = 1'b0;
    wait_cyc(2);
    alarm = 1'b1;
    wait_cyc(1);
    check("alarm_preempt", outv, V_ALARM);
    wait_cyc(3);
    ack = 1'b1;
    wait_cyc(1);
    ack = 1'b0;
    check("ack_to_hold", outv, V_HOLD);
    wait_cyc(2);
    alarm = 1'b0;
    drain();

    // alarm timeout, no retrigger while held, re-raise restarts
    scn = 4;
    push(V_ALARM, 0, ANY);
    push(V_HOLD, 29, 32);
    push(V_IDLE, 13, 16);
    push(V_ALARM, 3, 3);
    push(V_HOLD, 4, 4);
    push(V_IDLE, 3, 3);
    alarm = 1'b1;
    wait_cyc(45);
    alarm = 1'b0;
    wait_cyc(3);
    alarm = 1'b1;
    wait_cyc(4);
    ack = 1'b1;
    wait_cyc(1);
    ack = 1'b0;
    wait_cyc(2);
    alarm = 1'b0;
    drain();

    // async reset mid-alarm discards the pending timer
    scn = 5;
    push(V_ALARM, 0, ANY);
    push(V_IDLE, 0, ANY);
    push(V_CLICK, 0, ANY);
    push(V_IDLE, 5, 8);
    alarm = 1'b1;
    wait_cyc(2);
    timer = 1'b1;
    wait_cyc(1);
    timer = 1'b0;
    wait_cyc(2);
    check("alarm_before_reset", outv, V_ALARM);
    rst   = 1'b1;
    alarm = 1'b0;
    #1;
    check("async_reset", outv, V_IDLE);
    wait_cyc(2);
    rst = 1'b0;
    wait_cyc(20);
    click = 1'b1;
    wait_cyc(1);
    click = 1'b0;
    drain();

    // ack and retrigger together in TIMER: silence, no replay
    scn = 6;
    push(V_TIMER, 0, ANY);
    push(V_IDLE, 4, 4);
    timer = 1'b1;
    wait_cyc(1);
    timer = 1'b0;
    wait_cyc(3);
    ack   = 1'b1;
    timer = 1'b1;
    wait_cyc(1);
    ack   = 1'b0;
    timer = 1'b0;
    check("ack_with_retrigger", outv, V_IDLE);
    drain();

    // timer retrigger reloads the full duration
    scn = 7;
    push(V_TIMER, 0, ANY);
    push(V_IDLE, 23, 26);
    timer = 1'b1;
    wait_cyc(1);
    timer = 1'b0;
    wait_cyc(5);
    timer = 1'b1;
    wait_cyc(1);
    timer = 1'b0;
    drain();

    // click during click is pended and served after one idle cycle
    scn = 8;
    push(V_CLICK, 0, ANY);
    push(V_IDLE, 5, 8);
    push(V_CLICK, 1, 1);
    push(V_IDLE, 5, 8);
    click = 1'b1;
    wait_cyc(1);
    click = 1'b0;
    wait_cyc(1);
    click = 1'b1;
    wait_cyc(1);
    click = 1'b0;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #300000;
    failures++;
    $display("FAIL watchdog got=timeout want=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule
